// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Fetch front-end for the single-cycle core. Issues one word fetch at a time
// to a variable-latency instruction memory and buffers returned words, tagged
// with their address, in a DEPTH-entry FIFO. The oldest entry is presented to
// the core. A redirect flushes the FIFO and restarts fetching at the target;
// a response that is still in flight at that moment is waited for and dropped.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   imem_req/imem_addr  : fetch request and word address (held until granted)
//   imem_gnt            : memory accepts the request this cycle
//   imem_rvalid/rdata   : response for the single outstanding request
//   instr_valid         : FIFO head present
//   instruction/instr_pc: FIFO head word and its address (0 when empty)
//   instr_ready         : core consumes the head this cycle
//   redirect/redirect_pc: flush and restart fetch at redirect_pc (word aligned)
//   queue_count         : number of valid FIFO entries
//   dbg_state_o         : fetch FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DRAIN)
//
// Handshakes
//   Memory side: a request transfers on a cycle where imem_req && imem_gnt;
//   imem_req and imem_addr stay stable until then. Exactly one imem_rvalid
//   follows each transferred request, on a later cycle.
//   Core side: the head transfers on a cycle where instr_valid && instr_ready;
//   instr_ready is ignored while instr_valid is low.
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [31:0]              imem_rdata,
   output logic                     instr_valid,
   output logic [31:0]              instruction,
   output logic [31:0]              instr_pc,
   input  logic                     instr_ready,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic [$clog2(DEPTH):0]   queue_count,
   output logic [1:0]               dbg_state_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t        state_q;
   logic [31:0]   fetch_pc_q;
   logic [31:0]   req_pc_q;
   logic          imem_req_q;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   data_mem_q [DEPTH];

   logic          push;
   logic          pop;
   logic          not_empty;

   // Redirect wins over everything: a same-cycle response or pop is ignored.
   assign not_empty = (count_q != '0);
   assign push      = !redirect && (state_q == S_WAIT) && imem_rvalid;
   assign pop       = !redirect && not_empty && instr_ready;

   // ---------------------------------------------------------------------------
   // Fetch FSM. Only stored entries gate a new request: with a single request
   // outstanding and REQ entered only when a slot is free, the returning word
   // always has room.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC_W;
         req_pc_q   <= '0;
         imem_req_q <= 1'b0;
      end else if (redirect) begin
         fetch_pc_q <= redirect_pc & 32'hFFFF_FFFC;
         imem_req_q <= 1'b0;
         case (state_q)
            S_IDLE:  state_q <= S_IDLE;
            // A granted request has a response coming that must be swallowed.
            S_REQ:   state_q <= imem_gnt    ? S_DRAIN : S_IDLE;
            S_WAIT:  state_q <= imem_rvalid ? S_IDLE  : S_DRAIN;
            S_DRAIN: state_q <= imem_rvalid ? S_IDLE  : S_DRAIN;
            default: state_q <= S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_IDLE: begin
               if (count_q < CW'(DEPTH)) begin
                  state_q    <= S_REQ;
                  imem_req_q <= 1'b1;
               end
            end
            S_REQ: begin
               if (imem_gnt) begin
                  state_q    <= S_WAIT;
                  req_pc_q   <= fetch_pc_q;
                  imem_req_q <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  state_q    <= S_IDLE;
                  fetch_pc_q <= req_pc_q + 32'd4;
               end
            end
            S_DRAIN: begin
               if (imem_rvalid) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               imem_req_q <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO bookkeeping. Pointers wrap naturally because DEPTH is a power of 2.
   // ---------------------------------------------------------------------------
   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (redirect) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Storage needs no reset: entries are only visible once counted valid.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= req_pc_q;
         data_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign imem_req    = imem_req_q;
   assign imem_addr   = fetch_pc_q;
   assign instr_valid = not_empty;
   assign instruction = not_empty ? data_mem_q[rd_ptr_q] : 32'h0;
   assign instr_pc    = not_empty ? pc_mem_q[rd_ptr_q]   : 32'h0;
   assign queue_count = count_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// Bench for instr_fetch_queue: a directed vector table for the early cycles
// after reset, hand-written corner sequences (full queue, reset mid-fetch,
// PC wrap on a second instance) and a long randomized run. The reference is a
// queue of {pc, word} pairs plus the expected next fetch address, driven by a
// memory model that returns a fixed function of the address.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [1:0] ST_I = 2'd0, ST_R = 2'd1, ST_W = 2'd2, ST_D = 2'd3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   // ---------------- main instance ----------------
   logic          imem_req, imem_gnt, imem_rvalid;
   logic [31:0]   imem_addr, imem_rdata;
   logic          instr_valid, instr_ready, redirect;
   logic [31:0]   instruction, instr_pc, redirect_pc;
   logic [CW-1:0] queue_count;
   logic [1:0]    dbg_state;

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instruction (instruction),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .queue_count (queue_count),
      .dbg_state_o (dbg_state)
   );

   // ---------------- wrap instance (reset PC near the top) ----------------
   logic          w_req, w_gnt, w_rvalid, w_valid, w_ready, w_redirect;
   logic [31:0]   w_addr, w_rdata, w_instr, w_pc, w_redirect_pc;
   logic [CW-1:0] w_count;
   logic [1:0]    w_state;

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (w_req),
      .imem_addr   (w_addr),
      .imem_gnt    (w_gnt),
      .imem_rvalid (w_rvalid),
      .imem_rdata  (w_rdata),
      .instr_valid (w_valid),
      .instruction (w_instr),
      .instr_pc    (w_pc),
      .instr_ready (w_ready),
      .redirect    (w_redirect),
      .redirect_pc (w_redirect_pc),
      .queue_count (w_count),
      .dbg_state_o (w_state)
   );

   // ---------------- scoreboard state ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_q[$];      // {pc, word} the DUT should currently hold
   logic [31:0] m_fetch_pc;    // address the next granted request must carry
   logic        mem_busy;
   int          mem_lat;
   logic [31:0] mem_addr;
   logic        mem_stale;     // outstanding response belongs to a flushed stream

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0;
      w_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;
   endtask

   // Leaves the bench at a falling edge with reset just released.
   task automatic reset_dut();
      drive_idle();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      m_fetch_pc = 32'h0;
      mem_busy = 1'b0; mem_lat = 0; mem_stale = 1'b0; mem_addr = '0;
   endtask

   // One cycle against the reference: compare, drive memory/core inputs,
   // advance the reference across the coming edge, wait for the next fall.
   task automatic auto_cycle(input logic rdy, input logic redir, input logic [31:0] rpc,
                             input int gnt_pct, input int lat_min, input int lat_max);
      logic rv, g;
      check("count", queue_count, exp_q.size());
      check("valid", instr_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         check("head_pc", instr_pc, exp_q[0][63:32]);
         check("head_instr", instruction, exp_q[0][31:0]);
      end else begin
         check("empty_pc", instr_pc, 32'h0);
         check("empty_instr", instruction, 32'h0);
      end
      if (imem_req) check("req_with_free_slot", exp_q.size() < DEPTH, 1);

      rv = 1'b0; g = 1'b0;
      if (mem_busy) begin
         mem_lat--;
         if (mem_lat == 0) rv = 1'b1;
      end else if (imem_req && ($urandom_range(99) < gnt_pct)) begin
         g = 1'b1;
      end
      if (g) begin
         check("req_addr", imem_addr, m_fetch_pc);
         mem_busy  = 1'b1;
         mem_lat   = $urandom_range(lat_max, lat_min);
         mem_addr  = imem_addr;
         mem_stale = 1'b0;
      end
      imem_gnt    = g;
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_word(mem_addr) : $urandom;
      instr_ready = rdy;
      redirect    = redir;
      redirect_pc = rpc;

      if (redir) begin
         exp_q.delete();
         m_fetch_pc = rpc & 32'hFFFF_FFFC;
         if (mem_busy && !rv) mem_stale = 1'b1;
      end else begin
         if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
         if (rv && !mem_stale) begin
            exp_q.push_back({mem_addr, mem_word(mem_addr)});
            m_fetch_pc = mem_addr + 32'd4;
         end
      end
      if (rv) mem_busy = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      int          exp_count;
      logic [1:0]  exp_state;
   } vec_t;

   localparam int NV = 31;
   vec_t vt[NV];

   function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                               input logic rdy, input logic rdr, input logic [31:0] rpc,
                               input logic er, input logic [31:0] ea, input logic ev,
                               input logic [31:0] ep, input logic [31:0] ei,
                               input int ec, input logic [1:0] es);
      vec_t v;
      v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy; v.redir = rdr; v.rpc = rpc;
      v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
      v.exp_instr = ei; v.exp_count = ec; v.exp_state = es;
      return v;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic        found;
      int          k;
      logic        w_busy;
      logic [31:0] w_lat_addr;
      logic [31:0] exp_w[3];
      logic [31:0] rpc;
      int          rdy_pct;

      //          gnt rv rdata          rdy rdr rpc           | req addr          val pc            instr          cnt st
      vt[0]  = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         0, ST_I);
      vt[1]  = mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0,         0, 32'h0,         32'h0,         0, ST_R);
      vt[2]  = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         0, ST_W);
      vt[3]  = mk(0, 1, 32'h1111_0000,  0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         0, ST_W);
      vt[4]  = mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         1, 32'h0,         32'h1111_0000, 1, ST_I);
      vt[5]  = mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h4,         0, 32'h0,         32'h0,         0, ST_R);
      vt[6]  = mk(0, 1, 32'h2222_0004,  0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         0, ST_W);
      vt[7]  = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         1, 32'h4,         32'h2222_0004, 1, ST_I);
      vt[8]  = mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8,         1, 32'h4,         32'h2222_0004, 1, ST_R);
      vt[9]  = mk(0, 0, 32'h0,          0, 1, 32'h0000_0103,  0, 32'h0,         1, 32'h4,         32'h2222_0004, 1, ST_W);
      vt[10] = mk(0, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         0, ST_D);
      vt[11] = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         0, ST_I);
      vt[12] = mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h100,       0, 32'h0,         32'h0,         0, ST_R);
      vt[13] = mk(0, 1, 32'h4444_0100,  0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         0, ST_W);
      vt[14] = mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         1, 32'h100,       32'h4444_0100, 1, ST_I);
      vt[15] = mk(0, 0, 32'h0,          0, 1, 32'h0000_0200,  1, 32'h104,       0, 32'h0,         32'h0,         0, ST_R);
      vt[16] = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         0, ST_I);
      vt[17] = mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h200,       0, 32'h0,         32'h0,         0, ST_R);
      vt[18] = mk(0, 1, 32'h5555_0200,  0, 1, 32'h0000_0302,  0, 32'h0,         0, 32'h0,         32'h0,         0, ST_W);
      vt[19] = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         0, ST_I);
      vt[20] = mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h300,       0, 32'h0,         32'h0,         0, ST_R);
      vt[21] = mk(0, 1, 32'h3333_0300,  0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         0, ST_W);
      vt[22] = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         1, 32'h300,       32'h3333_0300, 1, ST_I);
      vt[23] = mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h304,       1, 32'h300,       32'h3333_0300, 1, ST_R);
      vt[24] = mk(0, 1, 32'h3333_0304,  0, 0, 32'h0,          0, 32'h0,         1, 32'h300,       32'h3333_0300, 1, ST_W);
      vt[25] = mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,         1, 32'h300,       32'h3333_0300, 2, ST_I);
      vt[26] = mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h308,       1, 32'h300,       32'h3333_0300, 2, ST_R);
      vt[27] = mk(0, 1, 32'h3333_0308,  1, 0, 32'h0,          0, 32'h0,         1, 32'h300,       32'h3333_0300, 2, ST_W);
      vt[28] = mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,         1, 32'h304,       32'h3333_0304, 2, ST_I);
      vt[29] = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h30C,       1, 32'h308,       32'h3333_0308, 1, ST_R);
      vt[30] = mk(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h30C,       0, 32'h0,         32'h0,         0, ST_R);

      // ---- reset values while reset is held ----
      drive_idle();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req", imem_req, 1'b0);
      check("rst_valid", instr_valid, 1'b0);
      check("rst_instr", instruction, 32'h0);
      check("rst_pc", instr_pc, 32'h0);
      check("rst_count", queue_count, 0);
      check("rst_state", dbg_state, ST_I);
      reset = 1'b1;

      // ---- directed table, row 0 is the cycle right after release ----
      for (int i = 0; i < NV; i++) begin
         imem_gnt    = vt[i].gnt;
         imem_rvalid = vt[i].rvalid;
         imem_rdata  = vt[i].rdata;
         instr_ready = vt[i].ready;
         redirect    = vt[i].redir;
         redirect_pc = vt[i].rpc;
         check($sformatf("v%0d_req", i), imem_req, vt[i].exp_req);
         if (vt[i].exp_req) check($sformatf("v%0d_addr", i), imem_addr, vt[i].exp_addr);
         check($sformatf("v%0d_valid", i), instr_valid, vt[i].exp_valid);
         check($sformatf("v%0d_pc", i), instr_pc, vt[i].exp_pc);
         check($sformatf("v%0d_instr", i), instruction, vt[i].exp_instr);
         check($sformatf("v%0d_count", i), queue_count, vt[i].exp_count);
         check($sformatf("v%0d_state", i), dbg_state, vt[i].exp_state);
         @(negedge clk);
      end

      // ---- PC wrap on the second instance ----
      reset_dut();
      exp_w[0] = 32'hFFFF_FFF8; exp_w[1] = 32'hFFFF_FFFC; exp_w[2] = 32'h0000_0000;
      w_ready = 1'b1; w_busy = 1'b0; w_lat_addr = '0; k = 0;
      for (int c = 0; c < 30 && k < 3; c++) begin
         if (w_valid) begin
            check("wrap_pc", w_pc, exp_w[k]);
            check("wrap_instr", w_instr, mem_word(exp_w[k]));
            k++;
         end
         w_rvalid = w_busy;
         w_rdata  = w_busy ? mem_word(w_lat_addr) : 32'h0;
         w_gnt    = w_req && !w_busy;
         if (w_gnt) w_lat_addr = w_addr;
         w_busy   = w_gnt;
         @(negedge clk);
      end
      check("wrap_delivered", k, 3);

      // ---- fill to full with the core stalled, then free one slot ----
      reset_dut();
      for (int c = 0; c < 20; c++) auto_cycle(1'b0, 1'b0, 32'h0, 100, 2, 2);
      check("full_count", queue_count, DEPTH);
      check("full_no_req", imem_req, 1'b0);
      auto_cycle(1'b1, 1'b0, 32'h0, 100, 2, 2);
      check("after_pop_count", queue_count, DEPTH - 1);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         if (imem_req) begin
            check("resume_addr", imem_addr, 32'h10);
            found = 1'b1;
         end else begin
            auto_cycle(1'b0, 1'b0, 32'h0, 100, 2, 2);
         end
      end
      check("resume_seen", found, 1'b1);

      // ---- asynchronous reset while a fetch is outstanding ----
      reset_dut();
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         auto_cycle(1'b0, 1'b0, 32'h0, 100, 3, 3);
         if (exp_q.size() == 2 && mem_busy) found = 1'b1;
      end
      check("midwait_reached", found, 1'b1);
      drive_idle();
      #2 reset = 1'b0;
      #1;
      check("async_req", imem_req, 1'b0);
      check("async_valid", instr_valid, 1'b0);
      check("async_instr", instruction, 32'h0);
      check("async_pc", instr_pc, 32'h0);
      check("async_count", queue_count, 0);
      exp_q.delete();
      m_fetch_pc = 32'h0;
      if (mem_busy) mem_stale = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 20; c++) auto_cycle(1'b1, 1'b0, 32'h0, 100, 1, 2);

      // ---- randomized traffic ----
      reset_dut();
      for (int c = 0; c < 3000; c++) begin
         rdy_pct = ((c / 400) % 2 == 1) ? 15 : 85;
         rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15))
                                        : $urandom_range(32'h0000_0FFF);
         auto_cycle($urandom_range(99) < rdy_pct, $urandom_range(99) < 3, rpc, 60, 1, 4);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Safety net; every loop above is bounded well inside this.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch front-end upstream of the single-cycle datapath: issues word fetches to a variable-latency instruction memory and buffers the returned words in a small FIFO.
- Presents the oldest word to the core as instruction/instr_pc with a valid/ready handshake.
- Branch/jump redirects (taken pc_source or jump, target = next-PC mux output) flush the queue and restart fetching at the target, discarding any in-flight response.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
imem_req  out  1  fetch request, held until granted
imem_addr  out  32  fetch word address, low 2 bits always 0
imem_gnt  in  1  memory accepts request this cycle (only meaningful with imem_req=1)
imem_rvalid  in  1  read data valid for the single outstanding request
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  head entry present
instruction  out  32  head instruction word (0 when empty)
instr_pc  out  32  address of head word (0 when empty)
instr_ready  in  1  core consumes head this cycle when instr_valid=1
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  new fetch address, bits[1:0] ignored (forced 0)
queue_count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (reset=0, async): state=IDLE, fetch_pc=RESET_PC, count=0, rd/wr pointers 0, imem_req=0, instr_valid=0, instruction=0, instr_pc=0, queue_count=0.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE: if count+0 < DEPTH go REQ (imem_req=1 next cycle, imem_addr=fetch_pc); else stay.
- REQ: imem_req=1, imem_addr stable until grant. On imem_gnt -> WAIT, latch req_pc=fetch_pc.
- WAIT: imem_req=0. On imem_rvalid: push {req_pc, imem_rdata} at wr pointer, fetch_pc=req_pc+4, -> IDLE. Issue condition in IDLE counts only stored entries, since at most one request is outstanding and REQ is entered only with a free slot.
- DRAIN: waits for the stale response; on imem_rvalid data discarded, -> IDLE.
- Redirect (priority over every other event in the same cycle):
  - fetch_pc=redirect_pc & ~3; count=0, pointers reset; same-cycle pop and push ignored.
  - IDLE or REQ without imem_gnt: -> IDLE (request withdrawn; new address issued from IDLE).
  - REQ with imem_gnt, or WAIT without imem_rvalid: -> DRAIN.
  - WAIT with imem_rvalid: response dropped, -> IDLE.
  - DRAIN without rvalid: stay DRAIN with new fetch_pc; DRAIN with rvalid: -> IDLE.
- Pop: instr_valid && instr_ready advances rd pointer, count-1. Push and pop in the same cycle: count unchanged.
- Full (count=DEPTH): no new request; pop frees a slot, fetch resumes from IDLE on the next cycle.
- Empty: instr_valid=0, instr_ready ignored.
- fetch_pc increments modulo 2^32 (0xFFFF_FFFC wraps to 0).
- imem_rvalid in IDLE/REQ is a protocol error, ignored, no state change.
- Pointers wrap modulo DEPTH.
- Outputs instruction/instr_pc are registered FIFO head muxed to 0 when empty; no combinational path from instr_ready or redirect to imem_req.
- Minimum latency: reset release -> imem_req at cycle 1; rvalid at cycle k -> instr_valid at cycle k+1.

Test Plan:
- Reset release, memory with gnt same cycle and rvalid 2 cycles later, instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8 with matching imem_rdata; instr_valid 0 during reset.
- instr_ready=0 for 20 cycles -> queue_count saturates at 4, imem_req stays 0 at full. Raise ready for 1 cycle -> count 3, next request at addr 0x10.
- Redirect to 0x0000_0103 while in WAIT -> stale rvalid data discarded; next imem_addr=0x0000_0100; first delivered instr_pc=0x100, queue_count=0 on the cycle after redirect.
- Redirect in REQ with imem_gnt=0 -> imem_req drops next cycle, no DRAIN; request reissued at the target. Redirect coincident with rvalid -> response dropped, no DRAIN entered.
- Simultaneous push and pop at count=2 -> count stays 2, head order preserved. RESET_PC=0xFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Assert reset mid-WAIT -> all outputs return to reset values immediately (async); the stale rvalid after release is ignored; first fetch is at RESET_PC.
